lcd_spi_tx: RTL and testbench
=============================

# lcd_spi_tx

Parametrised, FIFO-buffered SPI transmitter for serial LCD panels such as the ST7789. It replaces the fixed 100 MHz, 8-bit, mode-fixed sender used by the display path. It adds:
- a programmable SCL divider and selectable CPOL/CPHA;
- 8- or 16-bit frames per entry;
- an active-low chip select;
- a write-side FIFO with valid/ready handshake.

It sits between the display scan logic (or a CPU-mapped register port) and the panel pins.

## Interface
Parameters:
- CLK_DIV, 2: SCL half-period in clk_i cycles; legal values are 1 or more.
- FIFO_DEPTH, 16: entries; must be a power of 2, 2 or more.
- CPOL, 1: SCL idle level.
- CPHA, 1: 0 means SDA changes while SCL is idle and is sampled on the leading edge; 1 means SDA changes on the leading edge and is sampled on the trailing edge.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  sole clock
- rst_i  in  1  synchronous, active-high reset
- wr_valid_i  in  1  entry offered
- wr_ready_o  out  1  FIFO can accept (= !full)
- wr_dc_i  in  1  D/C level for the entry (0 = command, 1 = data)
- wr_wide_i  in  1  1: send wr_data_i[15:0]; 0: send wr_data_i[7:0]
- wr_data_i  in  16  payload, MSB first
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- idle_o  out  1  FIFO empty, engine IDLE, CS high
- spi_sda_o  out  1  serial data
- spi_scl_o  out  1  serial clock
- spi_dc_o  out  1  data/command
- spi_cs_n_o  out  1  chip select, active low

## Operation
FIFO:
- Each entry is 18 bits: {dc, wide, data}. A write is accepted when wr_valid_i && wr_ready_o.
- wr_ready_o depends only on full. A pop in the same cycle does not free space for that cycle's push.
- An entry written in cycle t is poppable from t+1.

Engine FSM: IDLE, LOAD, LEAD, TRAIL.
- IDLE: if the FIFO is non-empty, pop and go to LOAD.
- LOAD (1 cycle):
  - load the shift register, left-aligned: 16 bits if wide, otherwise data[7:0] into the upper byte;
  - load the bit counter with 16 or 8;
  - drive spi_dc_o = dc and spi_cs_n_o = 0;
  - if CPHA=0, drive spi_sda_o = MSB;
  - go to LEAD.
- LEAD (CLK_DIV cycles):
  - CPHA=0: SCL stays at CPOL. On exit, SCL goes to !CPOL.
  - CPHA=1: on entry, SCL = !CPOL and SDA = current MSB.
  - Go to TRAIL.
- TRAIL (CLK_DIV cycles):
  - CPHA=0: on exit, SCL returns to CPOL, the shift register moves left, and SDA takes the next bit.
  - CPHA=1: SCL returns to CPOL on entry, and the shift happens on exit.
  - The counter decrements on exit.
  - Counter still non-zero: go to LEAD.
  - Last bit, FIFO non-empty: pop and go to LOAD. CS stays low and DC updates in LOAD.
  - Last bit, FIFO empty: spi_cs_n_o = 1, go to IDLE.
- One divider counter (width $clog2(CLK_DIV)+1) times LEAD and TRAIL; it restarts on every state entry.
- spi_sda_o holds its last value while in IDLE.

Reset (rst_i = 1 at a clock edge), applied even mid-frame:
- FIFO emptied; level_o = 0; wr_ready_o = 1.
- State = IDLE; idle_o = 1.
- spi_scl_o = CPOL, spi_sda_o = 0, spi_dc_o = 0, spi_cs_n_o = 1.
- Writes offered during reset are dropped.

## Timing
- Frame length: 1 (LOAD) + 2·CLK_DIV·N cycles, with N = 8 or 16.
  - CLK_DIV=2, 8-bit: 33 cycles.
  - CLK_DIV=2, 16-bit: 65 cycles.
- Latency:
  - IDLE with an entry written at cycle t: pop at t+1, LOAD at t+2, CS low from t+2's edge.
  - Back-to-back entries: no CS gap, exactly 1 LOAD cycle between frames.
- SCL has exactly N active pulses per frame, each CLK_DIV cycles wide at !CPOL.
- SDA is stable for 2·CLK_DIV cycles around every sampling edge.
- level_o:
  - push only: +1 the next cycle;
  - pop only: −1;
  - simultaneous push and pop: unchanged.
- Full: level_o = FIFO_DEPTH and wr_ready_o = 0. Pointers wrap modulo FIFO_DEPTH.
- idle_o is registered. It asserts the cycle after CS goes high with the FIFO empty.

## Test plan
1. Reset with CPOL=1 -> SCL=1, CS_n=1, DC=0, SDA=0, level_o=0, ready=1, idle_o=1. Then reset mid-frame -> the same values the next cycle, and the FIFO is emptied.
2. CLK_DIV=2, CPOL=1, CPHA=1: write {dc=0, wide=0, 0x2A} -> DC=0; 8 SCL low pulses of 2 cycles each; SDA 0,0,1,0,1,0,1,0 sampled on rising edges; CS low for 33 cycles; idle_o returns high.
3. Write {dc=1, wide=1, 0xF800} -> 16 pulses with SDA 1111100000000000; CS low for 65 cycles.
4. Write 0x2B (command) then 0x00 (data) back-to-back -> CS stays low for 66 cycles; DC goes 0 to 1 in the single LOAD cycle between frames.
5. Hold wr_valid_i for 20 writes with FIFO_DEPTH=16 while the engine drains -> ready drops at level 16 and only handshaken entries are transmitted, in order with none lost; level_o is unchanged on a simultaneous push and pop.
6. CPOL=0, CPHA=0, CLK_DIV=1: send 0xA5 -> SCL idles 0; SDA is valid before each rising edge; frame lasts 17 cycles.

Source files
------------

// File: rtl/lcd_spi_tx.sv
// FIFO-buffered SPI transmitter for serial LCD panels (ST7789 class).
// Programmable SCL half-period, CPOL/CPHA, 8/16-bit frames and active-low CS.
module lcd_spi_tx #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CPOL       = 1,
    parameter int CPHA       = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic                        wr_dc_i,
    input  logic                        wr_wide_i,
    input  logic [15:0]                 wr_data_i,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        idle_o,
    output logic                        spi_sda_o,
    output logic                        spi_scl_o,
    output logic                        spi_dc_o,
    output logic                        spi_cs_n_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic POL = (CPOL != 0);
    localparam logic PHA = (CPHA != 0);

    typedef enum logic [1:0] {IDLE, LOAD, LEAD, TRAIL} state_t;

    // Entry layout: {dc, wide, data[15:0]}
    logic [17:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;
    logic [17:0]   head;

    assign full       = (count == FULL_LVL);
    assign empty      = (count == '0);
    assign push       = wr_valid_i && !full;
    assign head       = mem[rd_ptr];
    assign wr_ready_o = !full;
    assign level_o    = count;

    always_ff @(posedge clk_i) begin
        if (push && !rst_i)
            mem[wr_ptr] <= {wr_dc_i, wr_wide_i, wr_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [15:0]   sr, sr_nxt;
    logic          div_last, last_bit, shift, lead_entry, trail_entry;

    assign div_last    = (div_cnt == DIV_LAST);
    assign last_bit    = (bit_cnt == 5'd1);
    assign lead_entry  = (state_nxt == LEAD)  && (state != LEAD);
    assign trail_entry = (state_nxt == TRAIL) && (state != TRAIL);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // A pop always coincides with the transition into LOAD, so the popped
    // head is latched on that same edge and CS/DC are already valid in LOAD.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        shift     = 1'b0;
        unique case (state)
            IDLE: if (!empty) begin
                pop       = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: state_nxt = LEAD;
            LEAD: if (div_last) state_nxt = TRAIL;
            TRAIL: if (div_last) begin
                shift = 1'b1;
                if (!last_bit) begin
                    state_nxt = LEAD;
                end else if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sr_nxt = sr;
        if (shift) sr_nxt = {sr[14:0], 1'b0};
        if (pop)   sr_nxt = head[16] ? head[15:0] : {head[7:0], 8'h00};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sr         <= '0;
            spi_scl_o  <= POL;
            spi_sda_o  <= 1'b0;
            spi_dc_o   <= 1'b0;
            spi_cs_n_o <= 1'b1;
            idle_o     <= 1'b1;
        end else begin
            sr     <= sr_nxt;
            idle_o <= (state == IDLE) && empty && spi_cs_n_o;

            if (state_nxt != state)
                div_cnt <= '0;
            else if (state == LEAD || state == TRAIL)
                div_cnt <= div_cnt + 1'b1;

            if (shift) bit_cnt <= bit_cnt - 1'b1;
            if (pop) begin
                bit_cnt    <= head[16] ? 5'd16 : 5'd8;
                spi_dc_o   <= head[17];
                spi_cs_n_o <= 1'b0;
            end else if (shift && last_bit) begin
                spi_cs_n_o <= 1'b1;
            end

            // CPHA=0: the leading edge enters TRAIL; CPHA=1: the trailing edge does.
            if (trail_entry)          spi_scl_o <= PHA ? POL : !POL;
            if (shift && !PHA)        spi_scl_o <= POL;
            if (lead_entry && PHA) begin
                spi_scl_o <= !POL;
                spi_sda_o <= sr_nxt[15];
            end
            // SDA keeps the final bit once the frame ends into IDLE.
            if (!PHA && (pop || (shift && !last_bit)))
                spi_sda_o <= sr_nxt[15];
        end
    end
endmodule

// File: tb/tb_lcd_spi_tx.sv
// Bench for lcd_spi_tx: three configurations share one randomized write stream and
// are checked every cycle against a frame-timing model plus a few literal frame checks.
module tb_lcd_spi_tx;
    localparam int NU = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, dc_in = 1'b0, wide_in = 1'b0;
    logic [15:0] data_in = '0;

    logic        sda_w [NU], scl_w [NU], dc_w [NU], cs_w [NU], idle_w [NU], rdy_w [NU];
    logic [4:0]  lvl0, lvl1;
    logic [2:0]  lvl2;

    always #5 clk = ~clk;

    lcd_spi_tx #(.CLK_DIV(2), .FIFO_DEPTH(16), .CPOL(1), .CPHA(1)) u0 (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(valid), .wr_ready_o(rdy_w[0]),
        .wr_dc_i(dc_in), .wr_wide_i(wide_in), .wr_data_i(data_in), .level_o(lvl0),
        .idle_o(idle_w[0]), .spi_sda_o(sda_w[0]), .spi_scl_o(scl_w[0]),
        .spi_dc_o(dc_w[0]), .spi_cs_n_o(cs_w[0]));

    lcd_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(16), .CPOL(0), .CPHA(0)) u1 (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(valid), .wr_ready_o(rdy_w[1]),
        .wr_dc_i(dc_in), .wr_wide_i(wide_in), .wr_data_i(data_in), .level_o(lvl1),
        .idle_o(idle_w[1]), .spi_sda_o(sda_w[1]), .spi_scl_o(scl_w[1]),
        .spi_dc_o(dc_w[1]), .spi_cs_n_o(cs_w[1]));

    lcd_spi_tx #(.CLK_DIV(3), .FIFO_DEPTH(4), .CPOL(0), .CPHA(1)) u2 (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(valid), .wr_ready_o(rdy_w[2]),
        .wr_dc_i(dc_in), .wr_wide_i(wide_in), .wr_data_i(data_in), .level_o(lvl2),
        .idle_o(idle_w[2]), .spi_sda_o(sda_w[2]), .spi_scl_o(scl_w[2]),
        .spi_dc_o(dc_w[2]), .spi_cs_n_o(cs_w[2]));

    function automatic int pd(input int u);
        return (u == 0) ? 2 : (u == 1) ? 1 : 3;
    endfunction
    function automatic logic pol(input int u);
        return (u == 0);
    endfunction
    function automatic logic pha(input int u);
        return (u != 1);
    endfunction
    function automatic int dep(input int u);
        return (u == 2) ? 4 : 16;
    endfunction
    function automatic int lvl_of(input int u);
        return (u == 0) ? int'(lvl0) : (u == 1) ? int'(lvl1) : int'(lvl2);
    endfunction
    function automatic logic bitv(input logic [17:0] e, input int i);
        return e[16] ? e[15-i] : e[7-i];
    endfunction

    int n_chk = 0, n_err = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: FIFO as a circular array, frames as arithmetic on cycles since LOAD.
    logic [17:0] mq [NU][64];
    int          mh [NU], mcnt [NU], fstart [NU];
    bit          busy [NU];
    logic [17:0] cur [NU];
    logic        e_sda [NU], e_dc [NU], e_idle [NU];
    int          cyc = 0;
    bit          rst_seen = 0;

    // Frame monitor: CS-low length and the bits seen on each sampling edge.
    logic        prev_scl [NU];
    int          mon_len [NU], mon_nb [NU], mon_bits [NU];
    logic        mon_dc0 [NU];
    int          f_len [NU], f_nb [NU], f_bits [NU], f_cnt [NU];
    logic        f_dc0 [NU], f_dc1 [NU];

    initial begin
        for (int u = 0; u < NU; u++) begin
            mh[u] = 0; mcnt[u] = 0; busy[u] = 0; fstart[u] = 0; cur[u] = '0;
            e_sda[u] = 0; e_dc[u] = 0; e_idle[u] = 1;
            mon_len[u] = 0; mon_nb[u] = 0; mon_bits[u] = 0; mon_dc0[u] = 0;
            f_len[u] = 0; f_nb[u] = 0; f_bits[u] = 0; f_cnt[u] = 0; f_dc0[u] = 0; f_dc1[u] = 0;
        end
    end

    always @(negedge clk) begin : cmp_proc
        int   k, p, ph, nb;
        logic xs, xc, pushok, idle_n;
        for (int u = 0; u < NU; u++) begin
            xs = pol(u);
            xc = 1'b1;
            nb = cur[u][16] ? 16 : 8;
            if (busy[u]) begin
                k = cyc - fstart[u];
                xc = 1'b0;
                e_dc[u] = cur[u][17];
                if (k == 0) begin
                    if (!pha(u)) e_sda[u] = bitv(cur[u], 0);
                end else begin
                    p  = k - 1;
                    ph = p % (2 * pd(u));
                    e_sda[u] = bitv(cur[u], p / (2 * pd(u)));
                    if (!pha(u)) xs = (ph >= pd(u)) ? !pol(u) : pol(u);
                    else         xs = (ph <  pd(u)) ? !pol(u) : pol(u);
                end
            end
            if (rst_seen) begin
                cmp($sformatf("u%0d_cs_n", u),  cs_w[u],   xc);
                cmp($sformatf("u%0d_scl", u),   scl_w[u],  xs);
                cmp($sformatf("u%0d_sda", u),   sda_w[u],  e_sda[u]);
                cmp($sformatf("u%0d_dc", u),    dc_w[u],   e_dc[u]);
                cmp($sformatf("u%0d_idle", u),  idle_w[u], e_idle[u]);
                cmp($sformatf("u%0d_level", u), lvl_of(u), mcnt[u]);
                cmp($sformatf("u%0d_ready", u), rdy_w[u],  mcnt[u] < dep(u));
            end

            if (cs_w[u] === 1'b0) begin
                if (mon_len[u] == 0) mon_dc0[u] = dc_w[u];
                mon_len[u]++;
                if (scl_w[u] !== prev_scl[u] && scl_w[u] === (pha(u) ? pol(u) : !pol(u))) begin
                    mon_bits[u] = (mon_bits[u] << 1) | int'(sda_w[u]);
                    mon_nb[u]++;
                end
                f_dc1[u] = dc_w[u];
            end else if (mon_len[u] > 0) begin
                f_len[u] = mon_len[u]; f_nb[u] = mon_nb[u]; f_bits[u] = mon_bits[u];
                f_dc0[u] = mon_dc0[u]; f_cnt[u]++;
                mon_len[u] = 0; mon_nb[u] = 0; mon_bits[u] = 0;
            end
            prev_scl[u] = scl_w[u];

            if (rst) begin
                mh[u] = 0; mcnt[u] = 0; busy[u] = 0;
                e_idle[u] = 1; e_sda[u] = 0; e_dc[u] = 0;
            end else begin
                idle_n = !busy[u] && (mcnt[u] == 0);
                pushok = valid && (mcnt[u] < dep(u));
                if (busy[u] && (cyc - fstart[u]) == 2 * pd(u) * nb) busy[u] = 0;
                if (!busy[u] && mcnt[u] > 0) begin
                    cur[u] = mq[u][mh[u]];
                    mh[u] = (mh[u] + 1) % 64;
                    mcnt[u]--;
                    busy[u] = 1;
                    fstart[u] = cyc + 1;
                end
                if (pushok) begin
                    mq[u][(mh[u] + mcnt[u]) % 64] = {dc_in, wide_in, data_in};
                    mcnt[u]++;
                end
                e_idle[u] = idle_n;
            end
        end
        if (rst) rst_seen = 1;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic d, input logic w, input logic [15:0] v);
        valid = 1'b1; dc_in = d; wide_in = w; data_in = v;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (3) tick();
        while (!(idle_w[0] && idle_w[1] && idle_w[2]) && n < budget) begin
            tick();
            n++;
        end
        cmp("drain_within_budget", n < budget, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        cmp({tag, "_scl0"}, scl_w[0], 1'b1);
        cmp({tag, "_scl1"}, scl_w[1], 1'b0);
        for (int u = 0; u < NU; u++) begin
            cmp($sformatf("%s_cs%0d", tag, u),   cs_w[u],   1'b1);
            cmp($sformatf("%s_dc%0d", tag, u),   dc_w[u],   1'b0);
            cmp($sformatf("%s_sda%0d", tag, u),  sda_w[u],  1'b0);
            cmp($sformatf("%s_lvl%0d", tag, u),  lvl_of(u), 0);
            cmp($sformatf("%s_rdy%0d", tag, u),  rdy_w[u],  1'b1);
            cmp($sformatf("%s_idle%0d", tag, u), idle_w[u], 1'b1);
        end
    endtask

    initial begin : stim
        int base0, acc0, maxl0;
        bit saw_full;

        repeat (3) tick();
        rst = 1'b0;
        check_reset_vals("reset");

        // 8-bit command 0x2A
        base0 = f_cnt[0];
        write1(1'b0, 1'b0, 16'h002A);
        wait_idle(400);
        cmp("t2_frames", f_cnt[0] - base0, 1);
        cmp("t2_cs_len", f_len[0], 33);
        cmp("t2_pulses", f_nb[0], 8);
        cmp("t2_bits",   f_bits[0], 32'h2A);
        cmp("t2_dc",     f_dc0[0], 1'b0);
        cmp("t2_len_div1", f_len[1], 17);

        // 16-bit data 0xF800
        write1(1'b1, 1'b1, 16'hF800);
        wait_idle(400);
        cmp("t3_cs_len", f_len[0], 65);
        cmp("t3_pulses", f_nb[0], 16);
        cmp("t3_bits",   f_bits[0], 32'hF800);
        cmp("t3_dc",     f_dc0[0], 1'b1);

        // back-to-back command then data
        write1(1'b0, 1'b0, 16'h002B);
        write1(1'b1, 1'b0, 16'h0000);
        wait_idle(400);
        cmp("t4_cs_len", f_len[0], 66);
        cmp("t4_pulses", f_nb[0], 16);
        cmp("t4_bits",   f_bits[0], 32'h2B00);
        cmp("t4_dc_first", f_dc0[0], 1'b0);
        cmp("t4_dc_last",  f_dc1[0], 1'b1);

        // hold valid for 20 cycles against a busy engine
        acc0 = 0; maxl0 = 0; saw_full = 0;
        for (int i = 0; i < 20; i++) begin
            valid = 1'b1; dc_in = 1'($urandom); wide_in = 1'b0; data_in = 16'($urandom);
            if (rdy_w[0]) acc0++;
            else          saw_full = 1;
            if (int'(lvl0) > maxl0) maxl0 = int'(lvl0);
            tick();
        end
        valid = 1'b0;
        cmp("t5_accepted", acc0, 17);
        cmp("t5_max_level", maxl0, 16);
        cmp("t5_ready_dropped", saw_full, 1);
        cmp("t5_level_after", lvl0, 16);
        wait_idle(2000);
        cmp("t5_burst_len", f_len[0], 17 * 33);
        cmp("t5_burst_bits", f_nb[0], 17 * 8);

        // CPOL=0/CPHA=0, CLK_DIV=1
        write1(1'b1, 1'b0, 16'h00A5);
        wait_idle(400);
        cmp("t6_len", f_len[1], 17);
        cmp("t6_bits", f_bits[1], 32'hA5);
        cmp("t6_scl_idle", scl_w[1], 1'b0);

        // reset mid-frame, with a write offered during reset
        for (int i = 0; i < 3; i++) write1(1'b1, 1'b1, 16'(16'h1234 + i));
        repeat (10) tick();
        rst = 1'b1; valid = 1'b1; data_in = 16'hBEEF;
        tick();
        rst = 1'b0; valid = 1'b0;
        check_reset_vals("midrst");
        repeat (5) tick();
        cmp("midrst_lvl_hold", lvl0, 0);
        cmp("midrst_cs_hold", cs_w[0], 1'b1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            valid   = ($urandom_range(0, 3) == 0);
            dc_in   = 1'($urandom);
            wide_in = 1'($urandom);
            data_in = 16'($urandom);
            rst     = ($urandom_range(0, 699) == 0);
            tick();
        end
        valid = 1'b0; rst = 1'b0;
        wait_idle(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
